apb_initiator: RTL and testbench

APB_INITIATOR -- requirements
Module: apb_initiator

---
 rtl/apb_initiator.sv | 126 ++++++++++++
 tb/tb_apb_initiator.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/apb_initiator.sv
// Single-outstanding APB initiator: one request in, one APB transfer out, one response back.
// Wait states are counted in ACCESS; a nonzero TIMEOUT_CYCLES aborts a transfer the slave never completes.
module apb_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  input  logic [2:0]  req_prot,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic [31:0] out_paddr,
  output logic        out_psel,
  output logic        out_penable,
  output logic [2:0]  out_pprot,
  output logic        out_pwrite,
  output logic [31:0] out_pwdata,
  output logic [3:0]  out_pstrb,
  input  logic        out_pready,
  input  logic [31:0] out_prdata,
  input  logic        out_pslverr
);

  // state  | meaning
  // IDLE   | waiting for a request, req_ready high
  // SETUP  | APB setup phase, one cycle
  // ACCESS | APB access phase, waiting on pready or timeout
  // RESP   | response held until the consumer takes it
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [15:0] wait_cnt;
  logic        timeout_hit;

  // pready in the final allowed cycle wins over the timeout
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && !out_pready && (wait_cnt == TO_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    out_psel    = 1'b0;
    out_penable = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = SETUP;
      end
      SETUP: begin
        out_psel  = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        out_psel    = 1'b1;
        out_penable = 1'b1;
        if (out_pready || timeout_hit) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_paddr   <= '0;
      out_pwrite  <= 1'b0;
      out_pwdata  <= '0;
      out_pstrb   <= '0;
      out_pprot   <= '0;
      wait_cnt    <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        out_paddr  <= req_addr;
        out_pwrite <= req_write;
        out_pwdata <= req_wdata;
        out_pstrb  <= req_write ? req_wstrb : 4'b0000;
        out_pprot  <= req_prot;
      end

      // saturates rather than wrapping when the timeout is disabled
      if (state == SETUP)
        wait_cnt <= '0;
      else if (state == ACCESS && !out_pready && wait_cnt != 16'hFFFF)
        wait_cnt <= wait_cnt + 16'd1;

      if (state == ACCESS) begin
        if (out_pready) begin
          rsp_err     <= out_pslverr;
          rsp_rdata   <= out_pwrite ? 32'h0 : out_prdata;
          rsp_timeout <= 1'b0;
        end else if (timeout_hit) begin
          rsp_err     <= 1'b1;
          rsp_rdata   <= 32'h0;
          rsp_timeout <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_initiator.sv
// Directed and randomized transfers against apb_initiator with a small timeout,
// checked against a transaction-level expectation of phases, payload and response.
module tb_apb_initiator;

  localparam int T = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic [2:0]  req_prot = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [31:0] out_paddr;
  logic        out_psel;
  logic        out_penable;
  logic [2:0]  out_pprot;
  logic        out_pwrite;
  logic [31:0] out_pwdata;
  logic [3:0]  out_pstrb;
  logic        out_pready = 1'b0;
  logic [31:0] out_prdata = '0;
  logic        out_pslverr = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  apb_initiator #(.TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .out_paddr(out_paddr), .out_psel(out_psel), .out_penable(out_penable),
    .out_pprot(out_pprot), .out_pwrite(out_pwrite), .out_pwdata(out_pwdata),
    .out_pstrb(out_pstrb), .out_pready(out_pready), .out_prdata(out_prdata),
    .out_pslverr(out_pslverr)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_apb(input string ph, input logic [31:0] a, input logic w,
                         input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr);
    chk({ph, "_paddr"}, out_paddr, a);
    chk({ph, "_pwrite"}, 32'(out_pwrite), 32'(w));
    chk({ph, "_pwdata"}, out_pwdata, wd);
    chk({ph, "_pstrb"}, 32'(out_pstrb), 32'(st));
    chk({ph, "_pprot"}, 32'(out_pprot), 32'(pr));
    chk({ph, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({ph, "_req_ready"}, 32'(req_ready), 32'd0);
  endtask

  // Entered and left at 2 time units after a rising edge with the DUT idle.
  // waits = wait states before pready; waits >= T means the slave never answers in time.
  task automatic txn(input logic [31:0] a, input logic w, input logic [31:0] wd,
                     input logic [3:0] st, input logic [2:0] pr, input int waits,
                     input logic [31:0] pd, input logic se, input int rdelay);
    logic        to;
    int          n_acc;
    logic [3:0]  e_strb;
    logic [31:0] e_rdata;
    logic        e_err;
    to      = (waits >= T);
    n_acc   = to ? T : waits + 1;
    e_strb  = w ? st : 4'b0000;
    e_rdata = (w || to) ? 32'h0 : pd;
    e_err   = to ? 1'b1 : se;

    req_valid = 1'b1; req_addr = a; req_write = w; req_wdata = wd;
    req_wstrb = st; req_prot = pr;
    @(negedge clock);
    chk("idle_req_ready", 32'(req_ready), 32'd1);
    chk("idle_psel", 32'(out_psel), 32'd0);
    @(posedge clock); #1;
    req_valid = 1'b0; req_addr = $urandom; req_write = 1'($urandom);
    req_wdata = $urandom; req_wstrb = 4'($urandom); req_prot = 3'($urandom);
    out_pready = 1'($urandom); out_pslverr = 1'($urandom); out_prdata = $urandom;
    @(negedge clock);
    chk("setup_psel", 32'(out_psel), 32'd1);
    chk("setup_penable", 32'(out_penable), 32'd0);
    chk_apb("setup", a, w, wd, e_strb, pr);

    for (int k = 0; k < n_acc; k++) begin
      @(posedge clock); #1;
      out_pready  = (k == waits);
      out_prdata  = (k == waits) ? pd : $urandom;
      out_pslverr = (k == waits) ? se : 1'($urandom);
      @(negedge clock);
      chk("access_psel", 32'(out_psel), 32'd1);
      chk("access_penable", 32'(out_penable), 32'd1);
      chk_apb("access", a, w, wd, e_strb, pr);
    end

    @(posedge clock); #1;
    for (int d = 0; d <= rdelay; d++) begin
      rsp_ready   = (d == rdelay);
      out_pready  = 1'($urandom);
      out_pslverr = 1'($urandom);
      out_prdata  = $urandom;
      @(negedge clock);
      chk("resp_valid", 32'(rsp_valid), 32'd1);
      chk("resp_rdata", rsp_rdata, e_rdata);
      chk("resp_err", 32'(rsp_err), 32'(e_err));
      chk("resp_timeout", 32'(rsp_timeout), 32'(to));
      chk("resp_psel", 32'({out_psel, out_penable}), 32'd0);
      chk("resp_req_ready", 32'(req_ready), 32'd0);
      @(posedge clock); #1;
    end
    rsp_ready = 1'b0;
    #1;
    chk("after_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("after_req_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_psel", 32'({out_psel, out_penable}), 32'd0);
    chk("rst_paddr", out_paddr, 32'd0);
    chk("rst_rsp_payload", rsp_rdata | 32'({rsp_err, rsp_timeout}), 32'd0);
    @(negedge clock); @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;

    // read completing in the first ACCESS cycle
    txn(32'h0000_1000, 1'b0, 32'h0, 4'h0, 3'd1, 0, 32'hDEADBEEF, 1'b0, 0);
    // write with three wait states
    txn(32'h8000_0010, 1'b1, 32'h1234_5678, 4'b0011, 3'd2, 3, 32'hFFFF_FFFF, 1'b0, 0);
    // read with strobes offered, slave error
    txn(32'h0000_2004, 1'b0, 32'hAAAA_5555, 4'b1111, 3'd0, 1, 32'h0BAD_F00D, 1'b1, 0);
    // slave never answers, then answers in the last allowed cycle
    txn(32'h0000_3000, 1'b0, 32'h0, 4'h0, 3'd5, 100, 32'h1111_2222, 1'b0, 0);
    txn(32'h0000_3000, 1'b0, 32'h0, 4'h0, 3'd5, T - 1, 32'h3333_4444, 1'b0, 0);
    // consumer stalls the response for five cycles
    txn(32'h0000_4000, 1'b0, 32'h0, 4'h0, 3'd7, 0, 32'hCAFE_0001, 1'b0, 5);

    for (int i = 0; i < 30; i++) begin
      txn($urandom, 1'($urandom), $urandom, 4'($urandom), 3'($urandom),
          int'($urandom_range(0, 6)), $urandom, 1'($urandom),
          int'($urandom_range(0, 3)));
    end

    // reset in the middle of ACCESS
    req_valid = 1'b1; req_addr = 32'h0000_5000; req_write = 1'b0;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    out_pready = 1'b0;
    #2;
    chk("pre_rst_penable", 32'(out_penable), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_psel", 32'(out_psel), 32'd0);
    chk("mid_rst_penable", 32'(out_penable), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_paddr", out_paddr, 32'd0);
    out_pready = 1'b1; out_prdata = 32'h5555_AAAA;
    @(negedge clock);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("post_rst_psel", 32'(out_psel), 32'd0);
      chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    end
    out_pready = 1'b0;
    @(posedge clock); #1;
    txn(32'h0000_6000, 1'b1, 32'h0F0F_0F0F, 4'b1000, 3'd3, 2, 32'h0, 1'b0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
